inst_ram_1r1w_be: RTL and testbench

- Parametrised successor of the IF-stage 1r1w instruction RAM.
- Adds configurable data width and depth, byte-strobed writes, and a read enable that holds the output while the pipeline is stalled.
- Adds optional read-during-write bypass, an optional output pipeline register, a read-valid flag, and a built-in clear engine that fills the array with a NOP pattern after boot or on request.
- Sits between the IF-stage PC logic (read port) and the program loader/UART monitor (write port).

---
 rtl/inst_ram_1r1w_be.sv | 179 +++++++++++++++++
 tb/tb_inst_ram_1r1w_be.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_ram_1r1w_be.sv
// Instruction RAM: one read port and one write port with byte strobes.
// The read port has a stall-aware output path and an optional second stage.
// A clear engine fills the whole array with a NOP word after boot or on request.
module inst_ram_1r1w_be #(
   parameter int unsigned         IWIDTH   = 14,
   parameter int unsigned         DWIDTH   = 32,
   parameter int unsigned         OREG     = 0,
   parameter int unsigned         BYPASS   = 1,
   parameter logic [DWIDTH-1:0]   CLR_DATA = DWIDTH'(32'h0000_0013)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ram_ren,
   input  logic [IWIDTH-1:0]     ram_radr,
   output logic [DWIDTH-1:0]     ram_rdata,
   output logic                  ram_rvalid,
   input  logic                  ram_wen,
   input  logic [IWIDTH-1:0]     ram_wadr,
   input  logic [DWIDTH-1:0]     ram_wdata,
   input  logic [DWIDTH/8-1:0]   ram_wstrb,
   input  logic                  clr_start,
   output logic                  clr_busy
);

   localparam int unsigned DEPTH = 2 ** IWIDTH;
   localparam int unsigned NLANE = DWIDTH / 8;
   localparam int unsigned CW    = IWIDTH + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                busy_q, busy_d;

   logic [DWIDTH-1:0]   rd1_q, rd1_d;
   logic                v1_q, v1_d;
   logic [DWIDTH-1:0]   rd2_q, rd2_d;
   logic                v2_q, v2_d;

   logic [NLANE-1:0]    wr_we;
   logic [IWIDTH-1:0]   wr_adr;
   logic [DWIDTH-1:0]   wr_data;
   logic                wr_ext;
   logic [DWIDTH-1:0]   mem_rd;
   logic [DWIDTH-1:0]   merged;
   logic                coll;

   // Clear engine next-state: sweep addresses 0..DEPTH-1, stop on counter MSB
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            if (clr_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d[CW-1]) begin
               state_d = IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Clear engine state, counter and busy flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign clr_busy = busy_q;

   // Write port select: the clear sweep owns the array while busy, external writes are dropped
   always_comb begin
      wr_ext  = ram_wen && !busy_q;
      wr_we   = '0;
      wr_adr  = ram_wadr;
      wr_data = ram_wdata;
      if (busy_q) begin
         wr_we   = '1;
         wr_adr  = cnt_q[IWIDTH-1:0];
         wr_data = CLR_DATA;
      end else if (ram_wen) begin
         wr_we   = ram_wstrb;
      end
   end

   // Storage array; the collision attribute follows the bypass setting
   if (BYPASS != 0) begin : g_mem_byp
      (* ram_style = "block", rw_addr_collision = "yes" *)
      logic [DWIDTH-1:0] mem_q [DEPTH];

      // Byte-lane writes into the array
      always_ff @(posedge clk) begin
         for (int unsigned i = 0; i < NLANE; i++) begin
            if (wr_we[i]) mem_q[wr_adr][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end

      assign mem_rd = mem_q[ram_radr];
   end else begin : g_mem_nobyp
      (* ram_style = "block", rw_addr_collision = "no" *)
      logic [DWIDTH-1:0] mem_q [DEPTH];

      // Byte-lane writes into the array
      always_ff @(posedge clk) begin
         for (int unsigned i = 0; i < NLANE; i++) begin
            if (wr_we[i]) mem_q[wr_adr][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end

      assign mem_rd = mem_q[ram_radr];
   end

   // Collision merge: on equal addresses the read word is the old word at the write address,
   // so strobed lanes take new data and the rest keep the array contents
   always_comb begin
      coll   = ram_ren && wr_ext && (ram_radr == ram_wadr);
      merged = mem_rd;
      for (int unsigned i = 0; i < NLANE; i++) begin
         if (ram_wstrb[i]) merged[8*i +: 8] = ram_wdata[8*i +: 8];
      end
   end

   // Read pipeline next-state: both stages advance only on ram_ren, otherwise hold
   always_comb begin
      rd1_d = rd1_q;
      v1_d  = v1_q;
      rd2_d = rd2_q;
      v2_d  = v2_q;
      if (ram_ren) begin
         rd1_d = (BYPASS != 0 && coll) ? merged : mem_rd;
         v1_d  = !busy_q;
         rd2_d = rd1_q;
         v2_d  = v1_q;
      end
   end

   // Read pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd1_q <= '0;
         v1_q  <= 1'b0;
         rd2_q <= '0;
         v2_q  <= 1'b0;
      end else begin
         rd1_q <= rd1_d;
         v1_q  <= v1_d;
         rd2_q <= rd2_d;
         v2_q  <= v2_d;
      end
   end

   assign ram_rdata  = (OREG != 0) ? rd2_q : rd1_q;
   assign ram_rvalid = (OREG != 0) ? v2_q  : v1_q;

endmodule

// File: tb/tb_inst_ram_1r1w_be.sv
// Directed bench for inst_ram_1r1w_be: four instances cover the default build,
// BYPASS=0, OREG=1 and a 16-word array for the clear engine.
module tb_inst_ram_1r1w_be;

   logic        clk;
   logic        rst_n;
   logic        ren, wen, clr, clr_off;
   logic [13:0] radr, wadr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;

   logic [31:0] rd0, rd1, rd2, rd3;
   logic        rv0, rv1, rv2, rv3;
   logic        bz0, bz1, bz2, bz3;

   int total = 0;
   int bad   = 0;

   inst_ram_1r1w_be u_dut0 (
      .clk(clk), .rst_n(rst_n), .ram_ren(ren), .ram_radr(radr), .ram_rdata(rd0),
      .ram_rvalid(rv0), .ram_wen(wen), .ram_wadr(wadr), .ram_wdata(wdata),
      .ram_wstrb(wstrb), .clr_start(clr_off), .clr_busy(bz0));

   inst_ram_1r1w_be #(.BYPASS(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ram_ren(ren), .ram_radr(radr), .ram_rdata(rd1),
      .ram_rvalid(rv1), .ram_wen(wen), .ram_wadr(wadr), .ram_wdata(wdata),
      .ram_wstrb(wstrb), .clr_start(clr_off), .clr_busy(bz1));

   inst_ram_1r1w_be #(.OREG(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .ram_ren(ren), .ram_radr(radr), .ram_rdata(rd2),
      .ram_rvalid(rv2), .ram_wen(wen), .ram_wadr(wadr), .ram_wdata(wdata),
      .ram_wstrb(wstrb), .clr_start(clr_off), .clr_busy(bz2));

   inst_ram_1r1w_be #(.IWIDTH(4)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .ram_ren(ren), .ram_radr(radr[3:0]), .ram_rdata(rd3),
      .ram_rvalid(rv3), .ram_wen(wen), .ram_wadr(wadr[3:0]), .ram_wdata(wdata),
      .ram_wstrb(wstrb), .clr_start(clr), .clr_busy(bz3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
      wen = 1'b1; wadr = a; wdata = d; wstrb = s;
      tick();
      wen = 1'b0; wstrb = 4'h0;
   endtask

   task automatic rd(input logic [13:0] a);
      ren = 1'b1; radr = a;
      tick();
      ren = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      ren = 1'b0; wen = 1'b0; clr = 1'b0; clr_off = 1'b0;
      radr = '0; wadr = '0; wdata = '0; wstrb = '0;
      #2 rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      total++;
      if (rd0 !== 32'h0 || rv0 !== 1'b0) begin
         bad++;
         $display("FAIL reset_dut0 rdata=%h rvalid=%b expected 00000000/0", rd0, rv0);
      end
      total++;
      if (rd2 !== 32'h0 || rv2 !== 1'b0 || bz3 !== 1'b0) begin
         bad++;
         $display("FAIL reset_misc rd2=%h rv2=%b busy3=%b expected 0/0/0", rd2, rv2, bz3);
      end
   endtask

   task automatic test_write_read();
      wr(14'h010, 32'hDEADBEEF, 4'hF);
      rd(14'h010);
      total++;
      if (rd0 !== 32'hDEADBEEF || rv0 !== 1'b1) begin
         bad++;
         $display("FAIL write_read rdata=%h rvalid=%b expected deadbeef/1", rd0, rv0);
      end
      radr = 14'h011;
      tick();
      total++;
      if (rd0 !== 32'hDEADBEEF || rv0 !== 1'b1) begin
         bad++;
         $display("FAIL ren_low_hold rdata=%h rvalid=%b expected deadbeef/1", rd0, rv0);
      end
   endtask

   task automatic test_strobes();
      wr(14'h020, 32'h11223344, 4'hF);
      wr(14'h020, 32'hAABBCCDD, 4'b0101);
      rd(14'h020);
      total++;
      if (rd0 !== 32'h11BB33DD) begin
         bad++;
         $display("FAIL byte_strobe rdata=%h expected 11bb33dd", rd0);
      end
      wr(14'h020, 32'hFFFFFFFF, 4'h0);
      rd(14'h020);
      total++;
      if (rd0 !== 32'h11BB33DD) begin
         bad++;
         $display("FAIL zero_strobe rdata=%h expected 11bb33dd", rd0);
      end
   endtask

   task automatic test_collision();
      wr(14'h030, 32'h0, 4'hF);
      ren = 1'b1; radr = 14'h030;
      wen = 1'b1; wadr = 14'h030; wdata = 32'h12345678; wstrb = 4'hF;
      tick();
      ren = 1'b0; wen = 1'b0; wstrb = 4'h0;
      total++;
      if (rd0 !== 32'h12345678) begin
         bad++;
         $display("FAIL coll_bypass rdata=%h expected 12345678", rd0);
      end
      total++;
      if (rd1 !== 32'h00000000) begin
         bad++;
         $display("FAIL coll_nobypass rdata=%h expected 00000000", rd1);
      end
      rd(14'h030);
      total++;
      if (rd1 !== 32'h12345678) begin
         bad++;
         $display("FAIL coll_reread rdata=%h expected 12345678", rd1);
      end
      // partial-strobe collision: bypass merges lanes, no-bypass returns old word
      ren = 1'b1; radr = 14'h030;
      wen = 1'b1; wadr = 14'h030; wdata = 32'hAABBCCDD; wstrb = 4'b0011;
      tick();
      ren = 1'b0; wen = 1'b0; wstrb = 4'h0;
      total++;
      if (rd0 !== 32'h1234CCDD || rd1 !== 32'h12345678) begin
         bad++;
         $display("FAIL coll_partial byp=%h nobyp=%h expected 1234ccdd/12345678", rd0, rd1);
      end
      // different addresses do not interact
      ren = 1'b1; radr = 14'h020;
      wen = 1'b1; wadr = 14'h030; wdata = 32'h55555555; wstrb = 4'hF;
      tick();
      ren = 1'b0; wen = 1'b0; wstrb = 4'h0;
      total++;
      if (rd0 !== 32'h11BB33DD) begin
         bad++;
         $display("FAIL coll_diff_addr rdata=%h expected 11bb33dd", rd0);
      end
   endtask

   task automatic test_stall();
      wr(14'h001, 32'hA1A1A1A1, 4'hF);
      wr(14'h002, 32'hB2B2B2B2, 4'hF);
      ren = 1'b1; radr = 14'h001;
      tick();
      radr = 14'h002;
      tick();
      ren = 1'b0; radr = 14'h003;
      total++;
      if (rd2 !== 32'hA1A1A1A1 || rv2 !== 1'b1) begin
         bad++;
         $display("FAIL oreg_first rdata=%h rvalid=%b expected a1a1a1a1/1", rd2, rv2);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (rd2 !== 32'hA1A1A1A1) begin
            bad++;
            $display("FAIL oreg_stall_%0d rdata=%h expected a1a1a1a1", i, rd2);
         end
      end
      ren = 1'b1;
      tick();
      ren = 1'b0;
      total++;
      if (rd2 !== 32'hB2B2B2B2 || rv2 !== 1'b1) begin
         bad++;
         $display("FAIL oreg_resume rdata=%h rvalid=%b expected b2b2b2b2/1", rd2, rv2);
      end
   endtask

   task automatic test_clear();
      int n;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n = 0;
      while (bz3 === 1'b1 && n < 40) begin
         if (n == 10) begin
            wen = 1'b1; wadr = 14'h005; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
         end
         if (n == 11) begin
            wen = 1'b0; wstrb = 4'h0;
         end
         if (n == 6) clr = 1'b1;
         if (n == 7) clr = 1'b0;
         if (n == 8) begin
            ren = 1'b1; radr = 14'h000;
         end
         if (n == 9) begin
            ren = 1'b0;
            total++;
            if (rv3 !== 1'b0 || rd3 !== 32'h00000013) begin
               bad++;
               $display("FAIL read_while_busy rvalid=%b rdata=%h expected 0/00000013", rv3, rd3);
            end
         end
         tick();
         n++;
      end
      wen = 1'b0; ren = 1'b0; clr = 1'b0; wstrb = 4'h0;
      total++;
      if (n != 16) begin
         bad++;
         $display("FAIL busy_cycles got=%0d expected 16", n);
      end
      for (int a = 0; a < 16; a++) begin
         rd(14'(a));
         total++;
         if (rd3 !== 32'h00000013 || rv3 !== 1'b1) begin
            bad++;
            $display("FAIL clear_word_%0d rdata=%h rvalid=%b expected 00000013/1", a, rd3, rv3);
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      for (int a = 0; a < 7; a++) wr(14'(a), 32'hCAFE0000 + 32'(a), 4'hF);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      rst_n = 1'b0;
      #1;
      total++;
      if (bz3 !== 1'b0 || rd3 !== 32'h0 || rv3 !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_clear busy=%b rdata=%h rvalid=%b expected 0/0/0", bz3, rd3, rv3);
      end
      tick();
      rst_n = 1'b1;
      tick();
      total++;
      if (bz3 !== 1'b0) begin
         bad++;
         $display("FAIL busy_after_reset busy=%b expected 0", bz3);
      end
      for (int a = 0; a < 6; a++) begin
         rd(14'(a));
         total++;
         if (rd3 !== 32'h00000013) begin
            bad++;
            $display("FAIL partial_clear_%0d rdata=%h expected 00000013", a, rd3);
         end
      end
      rd(14'h006);
      total++;
      if (rd3 !== 32'hCAFE0006) begin
         bad++;
         $display("FAIL uncleared_6 rdata=%h expected cafe0006", rd3);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_strobes();
      test_collision();
      test_stall();
      test_clear();
      test_reset_mid_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
